// File: rtl/ahbl_ibus_dbus_arbiter.sv
// Purpose: shares one AHB-Lite master between instruction and data req/gnt/rvalid channels, pipelined.
// Latency: gnt in the address-phase cycle HREADY=1; rvalid in the data-phase cycle HREADY=1 (zero-wait: 1 cycle after gnt).
// Backpressure: HREADY=0 locks the owner and address; the pending data phase holds until HREADY=1.
module ahbl_ibus_dbus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        busy_o
);

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    logic             ap_lock;
    owner_t           ap_owner;
    logic             dp_valid;
    owner_t           dp_owner;
    logic             dp_we;
    logic [31:0]      dp_wdata;
    logic [CNT_W-1:0] starve_cnt;

    logic             sel_vld;
    owner_t           sel;
    logic             accept;
    logic             dp_done;
    logic [2:0]       be_size;
    logic [1:0]       be_off;
    logic             unused_addr_lsb;

    // The core presents a word address; the byte lane comes from the enables.
    assign unused_addr_lsb = ^data_addr_i[1:0];

    // Owner select: a stalled address phase keeps its owner, otherwise data wins unless instr is starved.
    always_comb begin
        sel_vld = 1'b0;
        sel     = OWN_DATA;
        if (ap_lock) begin
            sel_vld = 1'b1;
            sel     = ap_owner;
        end else if (instr_req_i && (!data_req_i || starve_cnt == LIMIT_C)) begin
            sel_vld = 1'b1;
            sel     = OWN_INSTR;
        end else if (data_req_i) begin
            sel_vld = 1'b1;
            sel     = OWN_DATA;
        end
        if (!HRESETn) begin
            sel_vld = 1'b0;
        end
    end

    // Byte enables to transfer size and low address bits; irregular patterns fall back to a word.
    always_comb begin
        be_size = 3'b010;
        be_off  = 2'b00;
        case (data_be_i)
            4'b0001: begin be_size = 3'b000; be_off = 2'b00; end
            4'b0010: begin be_size = 3'b000; be_off = 2'b01; end
            4'b0100: begin be_size = 3'b000; be_off = 2'b10; end
            4'b1000: begin be_size = 3'b000; be_off = 2'b11; end
            4'b0011: begin be_size = 3'b001; be_off = 2'b00; end
            4'b1100: begin be_size = 3'b001; be_off = 2'b10; end
            default: begin be_size = 3'b010; be_off = 2'b00; end
        endcase
    end

    // Address-phase drive, straight from the selected channel.
    always_comb begin
        HTRANS = sel_vld ? TRANS_NONSEQ : TRANS_IDLE;
        HADDR  = instr_addr_i;
        HSIZE  = 3'b010;
        HWRITE = 1'b0;
        HPROT  = 4'b0010;
        if (sel == OWN_DATA) begin
            HADDR  = {data_addr_i[31:2], be_off};
            HSIZE  = be_size;
            HWRITE = sel_vld & data_we_i;
            HPROT  = 4'b0011;
        end
    end

    assign accept  = sel_vld & HREADY;
    assign dp_done = HRESETn & dp_valid & HREADY;

    assign instr_gnt_o    = accept & (sel == OWN_INSTR);
    assign data_gnt_o     = accept & (sel == OWN_DATA);
    assign instr_rvalid_o = dp_done & (dp_owner == OWN_INSTR);
    assign data_rvalid_o  = dp_done & (dp_owner == OWN_DATA);
    assign instr_err_o    = instr_rvalid_o & HRESP;
    assign data_err_o     = data_rvalid_o & HRESP;
    assign instr_rdata_o  = HRDATA;
    // Stores return zero rather than whatever the slave leaves on HRDATA.
    assign data_rdata_o   = dp_we ? 32'h0 : HRDATA;
    assign HWDATA         = dp_wdata;
    assign busy_o         = dp_valid | (HTRANS == TRANS_NONSEQ);

    // Pipeline state: address-phase lock, data-phase tracker and instr starvation counter.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            ap_lock    <= 1'b0;
            ap_owner   <= OWN_INSTR;
            dp_valid   <= 1'b0;
            dp_owner   <= OWN_INSTR;
            dp_we      <= 1'b0;
            dp_wdata   <= 32'h0;
            starve_cnt <= '0;
        end else begin
            if (HREADY) begin
                ap_lock <= 1'b0;
            end else if (sel_vld) begin
                ap_lock  <= 1'b1;
                ap_owner <= sel;
            end

            if (HREADY) begin
                dp_valid <= accept;
                if (accept) begin
                    dp_owner <= sel;
                    dp_we    <= HWRITE;
                    dp_wdata <= data_wdata_i;
                end
            end

            if (!instr_req_i || instr_gnt_o) begin
                starve_cnt <= '0;
            end else if (data_gnt_o && starve_cnt != LIMIT_C) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/ahbl_ibus_dbus_arbiter.md
Name: ahbl_ibus_dbus_arbiter

Overview:
- Shares one AHB-Lite master port between the core's instruction and data request channels (req/gnt/rvalid protocol).
- Replaces the non-pipelined one-transfer-at-a-time sequencing with a proper AHB pipeline: the address phase of transfer N+1 overlaps the data phase of transfer N.
- Data has fixed priority, with a starvation guard for instruction fetch.
- Converts byte enables to HSIZE/HADDR[1:0] and returns HRESP as per-channel errors.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while instr_req_i is pending; the next grant then goes to instr.
- CNT_W, 3: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  synchronous reset, active low
- instr_req_i  in  1  fetch request; held with instr_addr_i until instr_gnt_o
- instr_addr_i  in  32  fetch address; word-aligned
- instr_gnt_o  out  1  fetch address phase accepted
- instr_rvalid_o  out  1  fetch data phase complete
- instr_rdata_o  out  32  fetch read data
- instr_err_o  out  1  fetch error; valid with instr_rvalid_o
- data_req_i  in  1  load/store request; held with attributes until data_gnt_o
- data_we_i  in  1  1 = store
- data_be_i  in  4  byte enables
- data_addr_i  in  32  word address
- data_wdata_i  in  32  store data
- data_gnt_o  out  1  load/store address phase accepted
- data_rvalid_o  out  1  load/store data phase complete
- data_rdata_o  out  32  load read data
- data_err_o  out  1  load/store error; valid with data_rvalid_o
- HADDR  out  32  AHB address
- HTRANS  out  2  AHB transfer type; IDLE=00, NONSEQ=10 only
- HSIZE  out  3  AHB transfer size
- HWRITE  out  1  AHB write control
- HPROT  out  4  AHB protection
- HWDATA  out  32  AHB write data
- HRDATA  in  32  AHB read data
- HREADY  in  1  AHB ready
- HRESP  in  1  AHB response; 1 = ERROR
- busy_o  out  1  data phase outstanding or address phase pending

Behaviour:
- Registers: ap_lock, ap_owner, dp_valid, dp_owner, dp_we, dp_wdata[31:0], starve_cnt.
- Reset: on an HCLK edge with HRESETn=0, all registers clear.
  - While HRESETn=0: HTRANS=00 and all gnt/rvalid/err outputs are 0.
  - Reset mid-transfer drops the outstanding transfer; no rvalid is issued for it.
- Owner select when ap_lock=0:
  - sel=INSTR if instr_req_i and (!data_req_i or starve_cnt==STARVE_LIMIT).
  - Otherwise sel=DATA if data_req_i.
  - When ap_lock=1, sel=ap_owner. The owner cannot change while an address phase is stalled.
- Address phase: HTRANS=NONSEQ whenever sel is valid; otherwise IDLE. Same cycle:
  - HADDR/HSIZE/HWRITE/HPROT come combinationally from the selected channel.
  - instr: HSIZE=010, HWRITE=0, HPROT=4'b0010.
  - data: HPROT=4'b0011.
- Acceptance: NONSEQ and HREADY=1 in the same cycle.
  - Pulse the owner's gnt_o for one cycle and set ap_lock=0.
  - Load dp_valid=1, dp_owner, dp_we, dp_wdata<=data_wdata_i.
- NONSEQ with HREADY=0: set ap_lock=1, ap_owner=sel; no gnt.
- Data phase:
  - HWDATA=dp_wdata.
  - When dp_valid and HREADY=1: pulse rvalid of dp_owner; rdata=HRDATA; err=HRESP.
  - dp_valid clears unless a new acceptance happens in the same cycle. Back-to-back: one transfer per cycle with zero-wait slaves.
- Error response: the first HRESP=1 cycle (HREADY=0) needs no action. The arbiter drives IDLE/NONSEQ normally; it does not cancel the pipelined next transfer.
- Byte-enable mapping, data_be_i -> HSIZE and HADDR[1:0]:
  - 0001, 0010, 0100, 1000 -> 000 with offset 00, 01, 10, 11.
  - 0011 -> 001, offset 00; 1100 -> 001, offset 10.
  - 1111 -> 010, offset 00.
  - Any other value -> 010, offset 00 (word access).
  - HADDR = {data_addr_i[31:2], offset}.
- Starvation counter:
  - Increments on a data acceptance while instr_req_i=1, saturating at STARVE_LIMIT.
  - Clears on an instr acceptance or when instr_req_i=0.
- Simultaneous req on both channels with counter below limit: data wins.
- busy_o = dp_valid | (HTRANS==NONSEQ).

Test Plan:
- Zero-wait slave, instr_req_i held, addrs 0x0,0x4,0x8 -> HTRANS NONSEQ three consecutive cycles; instr_gnt_o pulses cycles 0,1,2; instr_rvalid_o cycles 1,2,3; instr_rdata_o tracks HRDATA.
- Store be=1100 addr 0x100, wdata 0xAABB0000 -> HADDR=0x102, HSIZE=001, HWRITE=1, HPROT=0011; HWDATA=0xAABB0000 in the following cycle; data_rvalid_o one cycle later.
- Both reqs held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I then repeats; instr never waits more than 4 grants.
- HREADY=0 for 3 cycles during an instr address phase while data_req_i rises -> HADDR/HTRANS/owner stay on instr until HREADY=1; instr_gnt_o then, data granted next.
- Load with HRESP=1 two-cycle error -> data_rvalid_o=1 with data_err_o=1; following fetch completes with instr_err_o=0.
- HRESETn=0 for one edge with dp_valid=1 -> no rvalid issued; next cycle HTRANS=00, busy_o=0, starve_cnt=0.
